char_action_fsm: RTL and testbench

CHAR_ACTION_FSM -- requirements
Module: char_action_fsm

---
 rtl/char_pkg.sv | 45 ++++
 rtl/phase_counter.sv | 47 ++++
 rtl/char_action_fsm.sv | 158 +++++++++++++++
 tb/tb_char_action_fsm.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// -----------------------------------------------------------------------------
// char_pkg
// Shared definitions for the character action state machine:
//   - state_t    : 4-bit state encodings observed on the STATE port
//   - cnt_op_t   : operations the FSM requests from the phase counter
//   - DEF_*      : default frame-counter width and phase lengths
//   - len_ok()   : range check used to reject bad duration parameters
// -----------------------------------------------------------------------------
package char_pkg;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_LEFT         = 4'd1,
        ST_RIGHT        = 4'd2,
        ST_ATK_START    = 4'd3,
        ST_ATK_ACTIVE   = 4'd4,
        ST_ATK_RECOVERY = 4'd5,
        ST_DIR_START    = 4'd6,
        ST_DIR_ACTIVE   = 4'd7,
        ST_DIR_RECOVERY = 4'd8,
        ST_HITSTUN      = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        CNT_HOLD  = 2'd0,
        CNT_CLEAR = 2'd1,
        CNT_LOAD  = 2'd2,
        CNT_DEC   = 2'd3
    } cnt_op_t;

    localparam int DEF_CNT_W      = 5;
    localparam int DEF_N_START    = 5;
    localparam int DEF_N_ACTIVE   = 2;
    localparam int DEF_N_RECOVERY = 16;
    localparam int DEF_D_START    = 4;
    localparam int DEF_D_ACTIVE   = 3;
    localparam int DEF_D_RECOVERY = 15;
    localparam int DEF_N_HITSTUN  = 12;

    // A phase length must be loadable into the counter and last at least one frame.
    function automatic bit len_ok(input int len, input int cnt_w);
        return (len >= 1) && (len <= (1 << cnt_w) - 1);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Frame counter for timed phases. Acts only on cycles where i_tick is high.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears to 0)
//   i_tick         : frame-advance enable
//   i_op           : hold / clear / load / decrement request from the FSM
//   i_load_val     : value loaded on CNT_LOAD
//   o_cnt          : frames remaining in the current phase
//   o_done         : current frame is the last one of the phase (count <= 1)
// -----------------------------------------------------------------------------
module phase_counter
    import char_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  cnt_op_t          i_op,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            case (i_op)
                CNT_CLEAR: r_cnt <= '0;
                CNT_LOAD:  r_cnt <= i_load_val;
                // The FSM only decrements while o_done is low, so no underflow.
                CNT_DEC:   r_cnt <= r_cnt - 1'b1;
                default:   r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/char_action_fsm.sv
// -----------------------------------------------------------------------------
// char_action_fsm
// Frame-driven fighting-game character controller: idle, walking, neutral
// and directional attacks (start / active / recovery) and hitstun.
// Ports:
//   CLOCK, RESET_N              : clock, asynchronous active-low reset
//   FRAME_TICK                  : one-cycle frame strobe; all state advances on it
//   KEY_LEFT/KEY_RIGHT/KEY_ATTACK : debounced active-high controls
//   HIT_IN                      : character struck this frame (highest priority)
//   STATE                       : current state encoding (char_pkg::state_t)
//   FRAME_CNT                   : frames remaining in the current timed phase
//   ATTACK_ACTIVE               : hitbox live (ATK_ACTIVE or DIR_ACTIVE)
// -----------------------------------------------------------------------------
module char_action_fsm
    import char_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int N_START    = DEF_N_START,
    parameter int N_ACTIVE   = DEF_N_ACTIVE,
    parameter int N_RECOVERY = DEF_N_RECOVERY,
    parameter int D_START    = DEF_D_START,
    parameter int D_ACTIVE   = DEF_D_ACTIVE,
    parameter int D_RECOVERY = DEF_D_RECOVERY,
    parameter int N_HITSTUN  = DEF_N_HITSTUN
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             FRAME_TICK,
    input  logic             KEY_LEFT,
    input  logic             KEY_RIGHT,
    input  logic             KEY_ATTACK,
    input  logic             HIT_IN,
    output logic [3:0]       STATE,
    output logic [CNT_W-1:0] FRAME_CNT,
    output logic             ATTACK_ACTIVE
);

    if (!len_ok(N_START, CNT_W)    || !len_ok(N_ACTIVE, CNT_W)   ||
        !len_ok(N_RECOVERY, CNT_W) || !len_ok(D_START, CNT_W)    ||
        !len_ok(D_ACTIVE, CNT_W)   || !len_ok(D_RECOVERY, CNT_W) ||
        !len_ok(N_HITSTUN, CNT_W)) begin : g_bad_duration
        $error("char_action_fsm: every phase length must be in 1..2**CNT_W-1");
    end

    state_t           r_state;
    state_t           w_next_state;
    cnt_op_t          w_cnt_op;
    logic [CNT_W-1:0] w_load_val;
    logic             w_done;
    logic             w_key_same;
    logic             w_key_opp;

    // While walking: key for the current direction vs. the opposite one.
    assign w_key_same = (r_state == ST_LEFT) ? KEY_LEFT  : KEY_RIGHT;
    assign w_key_opp  = (r_state == ST_LEFT) ? KEY_RIGHT : KEY_LEFT;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else if (FRAME_TICK) begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cnt_op     = CNT_HOLD;
        w_load_val   = '0;
        if (HIT_IN) begin
            // A hit overrides everything, including an ongoing hitstun (combo).
            w_next_state = ST_HITSTUN;
            w_cnt_op     = CNT_LOAD;
            w_load_val   = CNT_W'(N_HITSTUN);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_op = CNT_CLEAR;
                    if (KEY_LEFT) begin
                        w_next_state = ST_LEFT;
                    end else if (KEY_RIGHT) begin
                        w_next_state = ST_RIGHT;
                    end else if (KEY_ATTACK) begin
                        w_next_state = ST_ATK_START;
                        w_cnt_op     = CNT_LOAD;
                        w_load_val   = CNT_W'(N_START);
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    w_cnt_op = CNT_CLEAR;
                    if (KEY_ATTACK) begin
                        w_next_state = ST_DIR_START;
                        w_cnt_op     = CNT_LOAD;
                        w_load_val   = CNT_W'(D_START);
                    end else if (w_key_opp) begin
                        w_next_state = (r_state == ST_LEFT) ? ST_RIGHT : ST_LEFT;
                    end else if (!w_key_same) begin
                        w_next_state = ST_IDLE;
                    end
                end
                // Timed phases: count down, then load the following phase length.
                ST_ATK_START, ST_ATK_ACTIVE, ST_DIR_START, ST_DIR_ACTIVE: begin
                    w_cnt_op = CNT_DEC;
                    if (w_done) begin
                        w_cnt_op = CNT_LOAD;
                        case (r_state)
                            ST_ATK_START: begin
                                w_next_state = ST_ATK_ACTIVE;
                                w_load_val   = CNT_W'(N_ACTIVE);
                            end
                            ST_ATK_ACTIVE: begin
                                w_next_state = ST_ATK_RECOVERY;
                                w_load_val   = CNT_W'(N_RECOVERY);
                            end
                            ST_DIR_START: begin
                                w_next_state = ST_DIR_ACTIVE;
                                w_load_val   = CNT_W'(D_ACTIVE);
                            end
                            default: begin
                                w_next_state = ST_DIR_RECOVERY;
                                w_load_val   = CNT_W'(D_RECOVERY);
                            end
                        endcase
                    end
                end
                ST_ATK_RECOVERY, ST_DIR_RECOVERY, ST_HITSTUN: begin
                    w_cnt_op = CNT_DEC;
                    if (w_done) begin
                        w_next_state = ST_IDLE;
                        w_cnt_op     = CNT_CLEAR;
                    end
                end
                default: begin
                    // Unused encodings recover to IDLE.
                    w_next_state = ST_IDLE;
                    w_cnt_op     = CNT_CLEAR;
                end
            endcase
        end
    end

    phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .i_clk      (CLOCK),
        .i_rst_n    (RESET_N),
        .i_tick     (FRAME_TICK),
        .i_op       (w_cnt_op),
        .i_load_val (w_load_val),
        .o_cnt      (FRAME_CNT),
        .o_done     (w_done)
    );

    assign STATE         = r_state;
    assign ATTACK_ACTIVE = (r_state == ST_ATK_ACTIVE) || (r_state == ST_DIR_ACTIVE);

endmodule

// File: tb/tb_char_action_fsm.sv
// -----------------------------------------------------------------------------
// tb_char_action_fsm
// Drives two instances (defaults, and CNT_W=6 / N_RECOVERY=40) with the same
// stimulus and compares them against a table-driven behavioural model.
// -----------------------------------------------------------------------------
module tb_char_action_fsm;

    localparam int S_IDLE = 0, S_LEFT = 1, S_RIGHT = 2, S_ATK_START = 3;
    localparam int S_ATK_ACTIVE = 4, S_ATK_RECOVERY = 5, S_DIR_START = 6;
    localparam int S_DIR_ACTIVE = 7, S_DIR_RECOVERY = 8, S_HITSTUN = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0, kl = 1'b0, kr = 1'b0, ka = 1'b0, hit = 1'b0;

    logic [3:0] st0, st1;
    logic [4:0] fc0;
    logic [5:0] fc1;
    logic       aa0, aa1;

    logic [3:0] obs_st [2];
    logic [7:0] obs_cnt[2];
    logic       obs_aa [2];
    assign obs_st[0]  = st0;
    assign obs_st[1]  = st1;
    assign obs_cnt[0] = {3'b000, fc0};
    assign obs_cnt[1] = {2'b00, fc1};
    assign obs_aa[0]  = aa0;
    assign obs_aa[1]  = aa1;

    int checks = 0;
    int failures = 0;

    // Behavioural model: per-instance state, frames remaining, phase lengths.
    int m_state[2];
    int m_cnt[2];
    int len_tbl[2][16];

    always #5 clk = ~clk;

    char_action_fsm u_dut0 (
        .CLOCK(clk), .RESET_N(rst_n), .FRAME_TICK(tick),
        .KEY_LEFT(kl), .KEY_RIGHT(kr), .KEY_ATTACK(ka), .HIT_IN(hit),
        .STATE(st0), .FRAME_CNT(fc0), .ATTACK_ACTIVE(aa0)
    );

    char_action_fsm #(.CNT_W(6), .N_RECOVERY(40)) u_dut1 (
        .CLOCK(clk), .RESET_N(rst_n), .FRAME_TICK(tick),
        .KEY_LEFT(kl), .KEY_RIGHT(kr), .KEY_ATTACK(ka), .HIT_IN(hit),
        .STATE(st1), .FRAME_CNT(fc1), .ATTACK_ACTIVE(aa1)
    );

    function automatic int next_phase(input int s);
        case (s)
            S_ATK_START:  return S_ATK_ACTIVE;
            S_ATK_ACTIVE: return S_ATK_RECOVERY;
            S_DIR_START:  return S_DIR_ACTIVE;
            S_DIR_ACTIVE: return S_DIR_RECOVERY;
            default:      return S_IDLE;
        endcase
    endfunction

    function automatic bit exp_active(input int k);
        return (m_state[k] == S_ATK_ACTIVE) || (m_state[k] == S_DIR_ACTIVE);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = S_IDLE;
            m_cnt[k]   = 0;
        end
    endtask

    task automatic model_step(input int k, input bit l, input bit r, input bit a, input bit h);
        int s;
        int ns;
        bit own;
        bit opp;
        s   = m_state[k];
        own = (s == S_LEFT) ? l : r;
        opp = (s == S_LEFT) ? r : l;
        if (h) begin
            m_state[k] = S_HITSTUN;
            m_cnt[k]   = len_tbl[k][S_HITSTUN];
        end else if (s >= S_ATK_START && s <= S_HITSTUN) begin
            if (m_cnt[k] > 1) begin
                m_cnt[k] = m_cnt[k] - 1;
            end else begin
                ns         = next_phase(s);
                m_state[k] = ns;
                m_cnt[k]   = (ns == S_IDLE) ? 0 : len_tbl[k][ns];
            end
        end else if (s == S_IDLE) begin
            if (l)      m_state[k] = S_LEFT;
            else if (r) m_state[k] = S_RIGHT;
            else if (a) begin
                m_state[k] = S_ATK_START;
                m_cnt[k]   = len_tbl[k][S_ATK_START];
            end
        end else if (s == S_LEFT || s == S_RIGHT) begin
            if (a) begin
                m_state[k] = S_DIR_START;
                m_cnt[k]   = len_tbl[k][S_DIR_START];
            end else if (opp) begin
                m_state[k] = (s == S_LEFT) ? S_RIGHT : S_LEFT;
            end else if (!own) begin
                m_state[k] = S_IDLE;
            end
        end else begin
            m_state[k] = S_IDLE;
            m_cnt[k]   = 0;
        end
    endtask

    // Drive one clock cycle of inputs, then advance the model on a tick.
    task automatic step(input bit t, input bit l, input bit r, input bit a, input bit h);
        @(negedge clk);
        tick = t; kl = l; kr = r; ka = a; hit = h;
        @(posedge clk);
        #1;
        if (t) begin
            for (int k = 0; k < 2; k++) model_step(k, l, r, a, h);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_st[k] !== 4'd0 || obs_cnt[k] !== 8'd0 || obs_aa[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset dut%0d: state=%0d cnt=%0d active=%b, required 0/0/0",
                         k, obs_st[k], obs_cnt[k], obs_aa[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_neutral_attack();
        int dur[2][16];
        int idle_tick;
        bit done;
        for (int k = 0; k < 2; k++) for (int s = 0; s < 16; s++) dur[k][s] = 0;
        idle_tick = 0;
        done = 1'b0;
        step(1, 0, 0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_st[k] !== 4'd3 || obs_cnt[k] !== 8'd5) begin
                failures++;
                $display("FAIL atk_entry dut%0d: state=%0d cnt=%0d, required 3/5", k, obs_st[k], obs_cnt[k]);
            end
            dur[k][obs_st[k]]++;
        end
        for (int t = 2; t <= 80 && !done; t++) begin
            step(1, 0, 0, 0, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_st[k] !== 4'(m_state[k]) || obs_cnt[k] !== 8'(m_cnt[k]) ||
                    obs_aa[k] !== exp_active(k)) begin
                    failures++;
                    $display("FAIL atk_seq dut%0d tick%0d: state=%0d cnt=%0d active=%b, required %0d/%0d/%b",
                             k, t, obs_st[k], obs_cnt[k], obs_aa[k], m_state[k], m_cnt[k], exp_active(k));
                end
                if (obs_st[k] != 4'd0) dur[k][obs_st[k]]++;
            end
            if (idle_tick == 0 && obs_st[0] == 4'd0) idle_tick = t;
            if (obs_st[0] == 4'd0 && obs_st[1] == 4'd0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL atk_timeout: state0=%0d state1=%0d, required both IDLE within 80 ticks", obs_st[0], obs_st[1]);
        end
        checks++;
        if (dur[0][3] != 5 || dur[0][4] != 2 || dur[0][5] != 16) begin
            failures++;
            $display("FAIL atk_durations: start=%0d active=%0d recovery=%0d, required 5/2/16",
                     dur[0][3], dur[0][4], dur[0][5]);
        end
        checks++;
        if (idle_tick != 24) begin
            failures++;
            $display("FAIL atk_idle_tick: idle at tick %0d, required 24", idle_tick);
        end
        checks++;
        if (dur[1][5] != 40) begin
            failures++;
            $display("FAIL wide_recovery: recovery=%0d ticks, required 40", dur[1][5]);
        end
    endtask

    task automatic test_directional();
        int dur[16];
        bit done;
        // {l, r, a} per tick and the required state/count afterwards.
        bit [2:0] keys[7] = '{3'b110, 3'b110, 3'b100, 3'b100, 3'b000, 3'b011, 3'b101};
        int exp_st[7]     = '{1, 2, 1, 1, 0, 2, 6};
        int exp_fc[7]     = '{0, 0, 0, 0, 0, 0, 4};
        for (int s = 0; s < 16; s++) dur[s] = 0;
        done = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1, keys[i][2], keys[i][1], keys[i][0], 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_st[k] !== 4'(exp_st[i]) || obs_cnt[k] !== 8'(exp_fc[i])) begin
                    failures++;
                    $display("FAIL walk_prio dut%0d step%0d: state=%0d cnt=%0d, required %0d/%0d",
                             k, i, obs_st[k], obs_cnt[k], exp_st[i], exp_fc[i]);
                end
            end
        end
        dur[6] = 1;
        for (int t = 0; t < 40 && !done; t++) begin
            step(1, 1, 0, 1, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_st[k] !== 4'(m_state[k]) || obs_cnt[k] !== 8'(m_cnt[k]) ||
                    obs_aa[k] !== exp_active(k)) begin
                    failures++;
                    $display("FAIL dir_seq dut%0d: state=%0d cnt=%0d active=%b, required %0d/%0d/%b",
                             k, obs_st[k], obs_cnt[k], obs_aa[k], m_state[k], m_cnt[k], exp_active(k));
                end
            end
            if (obs_st[0] == 4'd0) done = 1'b1;
            else dur[obs_st[0]]++;
        end
        checks++;
        if (!done || dur[6] != 4 || dur[7] != 3 || dur[8] != 15) begin
            failures++;
            $display("FAIL dir_durations: idle=%b start=%0d active=%0d recovery=%0d, required 1/4/3/15",
                     done, dur[6], dur[7], dur[8]);
        end
    endtask

    task automatic test_hitstun();
        bit found;
        found = 1'b0;
        step(1, 0, 0, 1, 0);
        for (int t = 0; t < 20 && !found; t++) begin
            if (obs_st[0] == 4'd4 && obs_cnt[0] == 8'd1) found = 1'b1;
            else step(1, 0, 0, 0, 0);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL hit_setup: state=%0d cnt=%0d, required ATK_ACTIVE with cnt 1", obs_st[0], obs_cnt[0]);
        end
        step(1, 1, 0, 1, 1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_st[k] !== 4'd9 || obs_cnt[k] !== 8'd12 || obs_aa[k] !== 1'b0) begin
                failures++;
                $display("FAIL hit_entry dut%0d: state=%0d cnt=%0d active=%b, required 9/12/0",
                         k, obs_st[k], obs_cnt[k], obs_aa[k]);
            end
        end
        repeat (4) step(1, 1, 1, 1, 0);
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_st[k] !== 4'd9 || obs_cnt[k] !== 8'd12) begin
                failures++;
                $display("FAIL hit_reload dut%0d: state=%0d cnt=%0d, required 9/12", k, obs_st[k], obs_cnt[k]);
            end
        end
        repeat (11) step(1, 0, 0, 1, 0);
        checks++;
        if (obs_st[0] !== 4'd9 || obs_cnt[0] !== 8'd1) begin
            failures++;
            $display("FAIL hit_last: state=%0d cnt=%0d, required 9/1", obs_st[0], obs_cnt[0]);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if (obs_st[0] !== 4'd0 || obs_cnt[0] !== 8'd0) begin
            failures++;
            $display("FAIL hit_exit: state=%0d cnt=%0d, required 0/0", obs_st[0], obs_cnt[0]);
        end
    endtask

    task automatic test_tick_gating();
        int hold_st;
        int hold_fc;
        step(1, 0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        hold_st = m_state[0];
        hold_fc = m_cnt[0];
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 1, 0);
            checks++;
            if (obs_st[0] !== 4'(hold_st) || obs_cnt[0] !== 8'(hold_fc)) begin
                failures++;
                $display("FAIL tick_hold cyc%0d: state=%0d cnt=%0d, required %0d/%0d",
                         i, obs_st[0], obs_cnt[0], hold_st, hold_fc);
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            if (m_state[0] == S_ATK_RECOVERY && m_cnt[0] == 9) found = 1'b1;
            else step(1, 0, 0, (m_state[0] == S_IDLE), 0);
        end
        checks++;
        if (!found || obs_st[0] !== 4'd5 || obs_cnt[0] !== 8'd9) begin
            failures++;
            $display("FAIL arst_setup: state=%0d cnt=%0d, required 5/9", obs_st[0], obs_cnt[0]);
        end
        @(negedge clk);
        tick = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_st[k] !== 4'd0 || obs_cnt[k] !== 8'd0 || obs_aa[k] !== 1'b0) begin
                failures++;
                $display("FAIL arst_immediate dut%0d: state=%0d cnt=%0d active=%b, required 0/0/0",
                         k, obs_st[k], obs_cnt[k], obs_aa[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 0, 0, 1, 0);
        checks++;
        if (obs_st[0] !== 4'd3 || obs_cnt[0] !== 8'd5) begin
            failures++;
            $display("FAIL arst_first_tick: state=%0d cnt=%0d, required 3/5", obs_st[0], obs_cnt[0]);
        end
    endtask

    task automatic test_random();
        bit t, l, r, a, h;
        for (int i = 0; i < 3000; i++) begin
            t = ($urandom_range(1, 0) == 1);
            l = ($urandom_range(3, 0) == 0);
            r = ($urandom_range(3, 0) == 0);
            a = ($urandom_range(2, 0) == 0);
            h = ($urandom_range(24, 0) == 0);
            step(t, l, r, a, h);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_st[k] !== 4'(m_state[k]) || obs_cnt[k] !== 8'(m_cnt[k]) ||
                    obs_aa[k] !== exp_active(k)) begin
                    failures++;
                    $display("FAIL random dut%0d cyc%0d: state=%0d cnt=%0d active=%b, required %0d/%0d/%b",
                             k, i, obs_st[k], obs_cnt[k], obs_aa[k], m_state[k], m_cnt[k], exp_active(k));
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 16; s++) len_tbl[k][s] = 0;
            len_tbl[k][S_ATK_START]    = 5;
            len_tbl[k][S_ATK_ACTIVE]   = 2;
            len_tbl[k][S_ATK_RECOVERY] = (k == 0) ? 16 : 40;
            len_tbl[k][S_DIR_START]    = 4;
            len_tbl[k][S_DIR_ACTIVE]   = 3;
            len_tbl[k][S_DIR_RECOVERY] = 15;
            len_tbl[k][S_HITSTUN]      = 12;
        end
        model_reset();
        test_reset();
        test_neutral_attack();
        test_directional();
        test_hitstun();
        test_tick_gating();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
